// File: rtl/tmu2_qpfill_pkg.sv
// Shared TMU2 cache-line geometry and refill FSM state type.
// The cache controller and the texel RAM are built around the same line geometry.
package tmu2_qpfill_pkg;

  localparam int unsigned LINE_OFS_BITS  = 5;
  localparam int unsigned BEATS_PER_LINE = 4;
  localparam int unsigned BEAT_W         = 64;
  localparam int unsigned LINE_W         = BEAT_W * BEATS_PER_LINE;
  localparam int unsigned BEAT_CNT_W     = $clog2(BEATS_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_WRITE
  } state_t;

endpackage

// File: rtl/tmu2_qpfill.sv
// TMU2 texel cache line refill: fetches a 4-beat FML burst, assembles a 256-bit
// line big-endian (beat0 in the MSBs), and writes it to the quad-port RAM once.
module tmu2_qpfill
  import tmu2_qpfill_pkg::*;
#(
  parameter int unsigned depth     = 11,
  parameter int unsigned fml_depth = 26
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,

  input  logic                              fill_stb,
  input  logic [fml_depth-LINE_OFS_BITS-1:0] fill_adr,
  output logic                              fill_busy,
  output logic                              fill_done,

  output logic [fml_depth-1:0]              fml_adr,
  output logic                              fml_stb,
  input  logic                              fml_ack,
  input  logic [BEAT_W-1:0]                 fml_di,

  output logic                              we,
  output logic [depth-1:0]                  wa,
  output logic [LINE_W-1:0]                 wd
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BEAT_CNT_W-1:0]   r_cnt;
  logic [BEAT_CNT_W-1:0]   w_cnt_nxt;
  logic                    r_stb;
  logic                    w_stb_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic                    r_we;
  logic                    w_we_nxt;
  logic [fml_depth-1:0]    r_fml_adr;
  logic [fml_depth-1:0]    w_fml_adr_nxt;
  logic [depth-1:0]        r_wa;
  logic [depth-1:0]        w_wa_nxt;
  logic [LINE_W-1:0]       r_line;
  logic [LINE_W-1:0]       w_line_nxt;

  // Every output is the next-state of a register, so the FML handshake and the
  // RAM write port see no combinational path through this block.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stb_nxt     = r_stb;
    w_busy_nxt    = r_busy;
    w_we_nxt      = 1'b0;
    w_fml_adr_nxt = r_fml_adr;
    w_wa_nxt      = r_wa;
    w_line_nxt    = r_line;

    unique case (r_state)
      S_IDLE: begin
        if (fill_stb) begin
          w_state_nxt   = S_REQ;
          w_stb_nxt     = 1'b1;
          w_busy_nxt    = 1'b1;
          w_fml_adr_nxt = {fill_adr, {LINE_OFS_BITS{1'b0}}};
          w_wa_nxt      = {fill_adr[depth-LINE_OFS_BITS-1:0], {LINE_OFS_BITS{1'b0}}};
        end
      end
      S_REQ: begin
        if (fml_ack) begin
          w_state_nxt = S_DATA;
          w_stb_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        // Left shift: the first beat ends up in the most significant 64 bits.
        w_line_nxt = {r_line[LINE_W-BEAT_W-1:0], fml_di};
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == BEAT_CNT_W'(BEATS_PER_LINE - 1)) begin
          w_state_nxt = S_WRITE;
          w_we_nxt    = 1'b1;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_stb     <= 1'b0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_fml_adr <= '0;
      r_wa      <= '0;
      r_line    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stb     <= w_stb_nxt;
      r_busy    <= w_busy_nxt;
      r_we      <= w_we_nxt;
      r_fml_adr <= w_fml_adr_nxt;
      r_wa      <= w_wa_nxt;
      r_line    <= w_line_nxt;
    end
  end

  assign fill_busy = r_busy;
  assign fill_done = r_we;
  assign fml_adr   = r_fml_adr;
  assign fml_stb   = r_stb;
  assign we        = r_we;
  assign wa        = r_wa;
  assign wd        = r_line;

endmodule

// File: tb/tb_tmu2_qpfill.sv
// Bench for tmu2_qpfill: FML slave model, write scoreboard and a texel RAM model.
module tb_tmu2_qpfill;

  localparam int unsigned DEPTH  = 11;
  localparam int unsigned FDEPTH = 26;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               fill_stb;
  logic [FDEPTH-6:0]  fill_adr;
  logic               fill_busy;
  logic               fill_done;
  logic [FDEPTH-1:0]  fml_adr;
  logic               fml_stb;
  logic               fml_ack;
  logic [63:0]        fml_di;
  logic               we;
  logic [DEPTH-1:0]   wa;
  logic [255:0]       wd;

  tmu2_qpfill #(.depth(DEPTH), .fml_depth(FDEPTH)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .fill_stb (fill_stb),
    .fill_adr (fill_adr),
    .fill_busy(fill_busy),
    .fill_done(fill_done),
    .fml_adr  (fml_adr),
    .fml_stb  (fml_stb),
    .fml_ack  (fml_ack),
    .fml_di   (fml_di),
    .we       (we),
    .wa       (wa),
    .wd       (wd)
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [FDEPTH-6:0] adr;
    int                dly;
    logic [63:0]       b [4];
  } rec_t;

  typedef struct {
    logic [DEPTH-1:0] wa;
    logic [255:0]     wd;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = -100;
  int stb_hi = 0;
  int we_count = 0;

  exp_t              sbq [$];
  logic [255:0]      ram [0:63];
  int                cur_delay = 0;
  logic [63:0]       cur_beats [4];
  logic [FDEPTH-1:0] exp_fml_adr = '0;
  logic              spur_ack = 1'b0;
  rec_t              tbl [5];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input rec_t r);
    exp_t e;
    e.wa = {r.adr[DEPTH-6:0], 5'b0};
    e.wd = {r.b[0], r.b[1], r.b[2], r.b[3]};
    return e;
  endfunction

  function automatic logic [15:0] rd16(input logic [DEPTH-1:0] a);
    logic [255:0] w;
    w = ram[a[DEPTH-1:5]];
    return w[255 - 8*int'(a[4:0]) -: 16];
  endfunction

  // FML slave: acks after cur_delay strobe cycles, then streams 4 beats without stalls.
  initial begin
    int s_beat;
    int stb_cnt;
    logic [63:0] lat [4];
    s_beat = -1;
    stb_cnt = 0;
    fml_ack = 1'b0;
    fml_di = '0;
    forever begin
      @(posedge sys_clk); #2;
      fml_ack = spur_ack;
      fml_di = {$urandom, $urandom};
      if (s_beat >= 0) begin
        fml_di = lat[s_beat];
        s_beat++;
        if (s_beat == 4) s_beat = -1;
      end else if (fml_stb) begin
        if (stb_cnt == cur_delay) begin
          fml_ack = 1'b1;
          ack_cyc = cyc;
          s_beat = 0;
          stb_cnt = 0;
          lat = cur_beats;
          chk("fml_adr", 256'(fml_adr), 256'(exp_fml_adr));
        end else begin
          stb_cnt++;
        end
      end
    end
  end

  // Write monitor: scoreboard pop, RAM model update, timing relative to ack.
  always @(negedge sys_clk) begin
    if (fml_stb) stb_hi++;
    if (cyc == ack_cyc + 1) chk("stb_drop", 256'(fml_stb), 256'(0));
    if (we || fill_done) begin
      chk("done_eq_we", 256'(fill_done), 256'(we));
      if (we) begin
        exp_t e;
        we_count++;
        chk("we_lat", 256'(cyc), 256'(ack_cyc + 5));
        if (sbq.size() == 0) begin
          chk("unexpected_we", 256'(1), 256'(0));
        end else begin
          e = sbq.pop_front();
          chk("wa", 256'(wa), 256'(e.wa));
          chk("wd", wd, e.wd);
        end
        ram[wa[DEPTH-1:5]] = wd;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_done(output int w);
    w = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (fill_done) begin
        w = cyc;
        break;
      end
    end
    if (w < 0) chk("done_timeout", 256'(0), 256'(1));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_fml_stb"}, 256'(fml_stb), 256'(0));
    chk({tag, "_we"}, 256'(we), 256'(0));
    chk({tag, "_done"}, 256'(fill_done), 256'(0));
    chk({tag, "_busy"}, 256'(fill_busy), 256'(0));
    chk({tag, "_fml_adr"}, 256'(fml_adr), 256'(0));
    chk({tag, "_wa"}, 256'(wa), 256'(0));
    chk({tag, "_wd"}, wd, 256'(0));
  endtask

  // Issue one fill from IDLE (called at posedge+1) and wait until it completes.
  task automatic issue(input rec_t r);
    int k;
    int w;
    cur_delay = r.dly;
    cur_beats = r.b;
    exp_fml_adr = {r.adr, 5'b0};
    sbq.push_back(mk_exp(r));
    stb_hi = 0;
    fill_adr = r.adr;
    fill_stb = 1'b1;
    k = cyc;
    tick();
    fill_stb = 1'b0;
    chk("accept_busy", 256'(fill_busy), 256'(1));
    chk("accept_stb", 256'(fml_stb), 256'(1));
    wait_done(w);
    chk("req_to_we", 256'(w), 256'(k + 6 + r.dly));
    chk("stb_cycles", 256'(stb_hi), 256'(r.dly + 1));
    tick();
    chk("busy_fall", 256'(fill_busy), 256'(0));
  endtask

  initial begin
    rec_t r1, r2;
    int w;
    int we_before;

    tbl[0] = '{adr: 21'h12345, dly: 3, b: '{64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002,
                                            64'h0003_0003_0003_0003, 64'h0004_0004_0004_0004}};
    tbl[1] = '{adr: 21'h00000, dly: 0, b: '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                            64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000}};
    tbl[2] = '{adr: 21'h1FFFFF, dly: 5, b: '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                                             64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF}};
    tbl[3] = '{adr: 21'h0002A, dly: 1, b: '{64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98,
                                            64'h7654_3210_CAFE_F00D, 64'hA5A5_5A5A_C3C3_3C3C}};
    tbl[4] = '{adr: 21'h15555, dly: 2, b: '{64'h8000_0000_0000_0001, 64'h4000_0000_0000_0002,
                                            64'h2000_0000_0000_0004, 64'h1000_0000_0000_0008}};

    sys_rst = 1'b1;
    fill_stb = 1'b0;
    fill_adr = '0;
    repeat (3) tick();
    chk_reset_outs("reset");
    sys_rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      issue(tbl[i]);
      repeat (2) tick();
    end

    for (int i = 0; i < 5; i++) begin
      logic [DEPTH-1:0] base;
      base = {tbl[i].adr[DEPTH-6:0], 5'b0};
      chk("rd_00", 256'(rd16(base | 11'h00)), 256'(tbl[i].b[0][63:48]));
      chk("rd_0E", 256'(rd16(base | 11'h0E)), 256'(tbl[i].b[1][15:0]));
      chk("rd_10", 256'(rd16(base | 11'h10)), 256'(tbl[i].b[2][63:48]));
      chk("rd_1E", 256'(rd16(base | 11'h1E)), 256'(tbl[i].b[3][15:0]));
    end

    // fill_stb held across two fills: the second is only taken once busy drops.
    r1 = tbl[3];
    r2 = tbl[4];
    r2.adr = 21'h0BEEF;
    cur_delay = 0;
    cur_beats = r1.b;
    exp_fml_adr = {r1.adr, 5'b0};
    sbq.push_back(mk_exp(r1));
    stb_hi = 0;
    fill_adr = r1.adr;
    fill_stb = 1'b1;
    tick();
    fill_adr = r2.adr;
    chk("hold_busy1", 256'(fill_busy), 256'(1));
    wait_done(w);
    tick();
    chk("hold_gap_busy", 256'(fill_busy), 256'(0));
    chk("hold_one_stb", 256'(stb_hi), 256'(1));
    cur_beats = r2.b;
    exp_fml_adr = {r2.adr, 5'b0};
    sbq.push_back(mk_exp(r2));
    tick();
    chk("hold_busy2", 256'(fill_busy), 256'(1));
    chk("hold_stb2", 256'(fml_stb), 256'(1));
    fill_stb = 1'b0;
    wait_done(w);
    repeat (2) tick();

    // Reset during beat 2 aborts the line without a write.
    cur_delay = 1;
    cur_beats = tbl[2].b;
    exp_fml_adr = {21'h0F0F0, 5'b0};
    ack_cyc = -100;
    fill_adr = 21'h0F0F0;
    fill_stb = 1'b1;
    tick();
    fill_stb = 1'b0;
    for (int i = 0; i < 20 && ack_cyc < 0; i++) tick();
    chk("rst_ack_seen", 256'(ack_cyc >= 0), 256'(1));
    while (ack_cyc >= 0 && cyc < ack_cyc + 3) tick();
    sys_rst = 1'b1;
    we_before = we_count;
    tick();
    sys_rst = 1'b0;
    chk_reset_outs("midrst");
    repeat (8) tick();
    chk("midrst_no_we", 256'(we_count), 256'(we_before));

    // Spurious ack in IDLE with no request.
    spur_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_idle", 256'({fml_stb, we, fill_busy}), 256'(0));
    end
    spur_ack = 1'b0;
    tick();

    issue(tbl[1]);
    repeat (3) tick();
    chk("sb_empty", 256'(sbq.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tmu2_qpfill.md
# tmu2_qpfill

Cache line refill engine for the TMU2 texel cache. It fetches one 32-byte line from FML as a 4-beat 64-bit burst and assembles it into a 256-bit word. It then writes that word into the quad-port texel RAM through its single 256-bit write port. It sits between the cache tag/miss controller (upstream) and the quad-port RAM write port (downstream).

## Interface
Parameters:
- depth, 11, log2 of texel RAM capacity in bytes; must match the RAM instance.
- fml_depth, 26, FML byte address width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- fill_stb  in  1  refill request; sampled only when fill_busy=0.
- fill_adr  in  fml_depth-5  line address (byte address >> 5).
- fill_busy  out  1  high from the cycle after acceptance until the cycle after the write.
- fill_done  out  1  one-cycle pulse, coincident with we.
- fml_adr  out  fml_depth  burst byte address, low 5 bits zero.
- fml_stb  out  1  FML request strobe.
- fml_ack  in  1  FML acknowledge.
- fml_di  in  64  FML read data.
- we  out  1  RAM write enable; high for exactly one cycle per line.
- wa  out  depth  RAM byte address, 256-bit aligned.
- wd  out  256  RAM write data.

## Operation
- FSM states:
  - IDLE: fill_busy=0. If fill_stb=1, latch fml_adr={fill_adr,5'b0} and wa={fill_adr[depth-6:0],5'b0}, then go to REQ.
  - REQ: fml_stb=1. Hold fml_adr stable until fml_ack=1, then go to DATA with beat counter=0.
  - DATA: each cycle, shift fml_di into the line register and increment the 2-bit counter. After beat 3, go to WRITE.
  - WRITE: we=1, fill_done=1, then go to IDLE.
- Beat order is big-endian within the line:
  - beat0 → wd[255:192]
  - beat1 → wd[191:128]
  - beat2 → wd[127:64]
  - beat3 → wd[63:0]
  - Consequence: byte offset 0 lands in the most significant halfword of RAM port 0's half.
- wd and wa are registered and hold their values outside WRITE. They are don't-care when we=0.
- fill_stb is ignored while fill_busy=1. No queueing.
- During WRITE the RAM read ports return garbage. The upstream controller must not consume read data in the cycle after WRITE for addresses presented during WRITE. fill_done marks that cycle.
- Reset values: state=IDLE, fml_stb=0, we=0, fill_done=0, fill_busy=0, beat counter=0, fml_adr=0, wa=0, wd=0.
- Reset mid-burst returns to IDLE immediately. Beats still arriving are ignored and no write occurs.
- fml_ack outside REQ is ignored.

## Timing
- fill_stb accepted at edge N (state IDLE):
  - fml_stb and fill_busy high from cycle N+1.
  - Earliest fml_ack is in cycle N+1.
- fml_ack in cycle A:
  - Data beats are valid on fml_di in cycles A+1..A+4, one per cycle, with no stalls (FML rule).
  - fml_stb drops in cycle A+1.
- we and fill_done are high in cycle A+5.
- fill_busy falls in cycle A+6, and a new fill_stb can be accepted at edge A+6.
- Minimum request-to-write latency is 6 cycles. Back-to-back refills take 6 + (ack wait) cycles each.
- The fml_stb/fml_ack handshake has no combinational path. All outputs are registered.

## Structure
- Single flat module, with no sub-module.
- The state encoding is local parameters: IDLE, REQ, DATA, WRITE.
- Line geometry goes in the shared tmu2 constants include: line offset bits = 5, beats per line = 4, FML beat width = 64. The cache controller and texel RAM use the same values.
- Line register: 256-bit left-shift register, 64 bits per beat, driving wd directly.

## Test plan
1. Single fill:
   - Stimulus: fill_adr=0x12345, fml_ack 3 cycles after fml_stb, beats 0x0001…, 0x0002…, 0x0003…, 0x0004….
   - Required: fml_adr=0x02468A0; wa = low bits of {0x12345,5'b0} truncated to depth; wd = beats concatenated beat0 in the MSBs; one-cycle we coincident with fill_done, exactly 5 cycles after ack.
2. Immediate ack:
   - Stimulus: fml_ack in the first fml_stb cycle.
   - Required: we 6 cycles after fill_stb is accepted; fml_stb high for exactly 1 cycle.
3. fill_stb held high continuously across two fills with different addresses.
   - Required: the second request is accepted only at the cycle fill_busy is low; no second fml_stb before the first we.
4. sys_rst asserted during beat 2.
   - Required: next cycle all outputs are at reset values; no we for the aborted line; a following fill completes correctly.
5. Spurious fml_ack while IDLE, and fill_stb=0.
   - Required: no state change; we, fml_stb and fill_busy stay 0.
6. Write readback through the real RAM model:
   - Stimulus: after fill_done, read offsets 0x00, 0x0E, 0x10 and 0x1E via the four read ports.
   - Required: returned halfwords are wd[255:240], wd[143:128], wd[127:112] and wd[15:0] respectively.
